priority_grant_sequencer: RTL
=============================

// Module: priority_grant_sequencer
// PURPOSE
//  Captures per-source request pulses into sticky pending bits and grants them one at a time, highest index first.
//  Presents each grant as an id on a valid/ready output. Sits upstream of downstream consumers of encoded ids,
//  e.g. interrupt dispatch or a shared-resource controller.
//  Turns transient, simultaneous requests into an ordered, lossless-where-possible grant stream.
// PARAMETERS
//  NUM_REQ   4                  number of request sources (>=2)
//  ID_WIDTH  $clog2(NUM_REQ)    localparam; width of granted id
// PORTS
//  clk        in   1         clock; all logic on rising edge
//  rst_n      in   1         synchronous, active-low reset
//  req        in   NUM_REQ   request pulses/levels, sampled every cycle
//  out_id     out  ID_WIDTH  granted source index
//  out_valid  out  1         out_id is valid
//  out_ready  in   1         consumer accepts out_id
//  pending    out  NUM_REQ   current pending vector (status/debug)
//  merged     out  1         1-cycle pulse: a request hit an already-pending bit
//  mask       in   NUM_REQ   only with PRIORITY_GRANT_MASK_EN; 1 = source ineligible
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): pending=0, out_valid=0, out_id=0, merged=0, FSM=IDLE.
//    Reset mid-operation discards all pending and any presented grant; out_valid=0 the following cycle.
//  Handshake: hs = out_valid & out_ready.
//  Pending update per edge: pending[i] <= req[i] | (pending[i] & ~(hs & out_id==i)).
//    Set wins over clear: a req on a bit granted in the same cycle leaves it pending.
//  merged <= |(req & pending & ~clr_vec); clr_vec is the one-hot of out_id when hs.
//    Only repeats that are genuinely lost raise merged.
//  Eligible vector: elig = pending & ~clr_vec; with the mask feature, also & ~mask.
//    A req arriving this cycle is NOT eligible until it is in pending.
//  Selection: highest set index of elig. Combinational priority encode; result registered into out_id.
//  FSM (state enum in pkg):
//    IDLE: if |elig -> load out_id, out_valid<=1, go PRESENT; else stay, out_valid=0.
//    PRESENT: !out_ready -> hold out_id/out_valid stable. A higher-priority arrival does NOT preempt
//      (AXI-style stability). hs -> if |elig, load next id, stay PRESENT (back-to-back, 1 grant/cycle);
//      else out_valid<=0, go IDLE.
//  Latency: req at edge k sets pending; out_valid rises at edge k+1 when IDLE (2 cycles req->visible grant).
//  out_id is don't-care when out_valid=0; it holds its last value, 0 after reset.
//  All NUM_REQ requesting in one cycle: granted in order NUM_REQ-1 ... 0 over consecutive hs cycles.
// CONFIGURATION
//  PRIORITY_GRANT_MASK_EN defined: mask port exists.
//    Masked bits still set/hold pending but are never selected.
//    Masking the presented id does not retract it; it stays until hs.
//  Undefined: no mask port; every pending bit is eligible.
// STRUCTURE
//  priority_grant_pkg: state_t {IDLE, PRESENT}; function onehot(id, n).
//  Sub-module priority_encoder_param #(NUM_REQ): combinational, in[NUM_REQ] -> id[ID_WIDTH], valid;
//    highest index wins.
//  Top level: pending register, FSM, output registers, merged logic.
// TESTING
//  1 Reset: rst_n=0 with req=4'b1111 for 2 cycles -> pending=0, out_valid=0, out_id=0, merged=0.
//  2 Single: req=4'b0100 one cycle, out_ready=1 -> out_valid=1, out_id=2 two edges later;
//    pending=0 after hs; out_valid=0 next cycle.
//  3 Burst with stall: req=4'b1011 one cycle, out_ready=0 for 3 cycles -> out_id=3 held stable.
//    Then ready=1 -> ids 3,1,0 on consecutive cycles; then out_valid=0.
//  4 No preempt / set-wins: presenting id=1 (ready=0), assert req[3] -> out_id stays 1.
//    On hs with req[1]=1 in the same cycle -> next id=3, then 1 again; merged=0.
//  5 Merge: pending[2]=1, not presented, req[2]=1 -> merged pulses 1 cycle; only one id=2 grant results.
//  6 MASK_EN build: mask=4'b1000, req=4'b1001 -> only id=0 granted, pending=4'b1000 remains.
//    Clear mask -> id=3 granted.

Source files
------------

// File: rtl/priority_grant_pkg.sv
// -----------------------------------------------------------------------------
// priority_grant_pkg
// Shared types and helpers for the priority grant sequencer.
//   state_t  : grant FSM states (IDLE = nothing presented, PRESENT = id on output)
//   onehot() : one-hot decode of an index, bits at or above n forced to zero
// -----------------------------------------------------------------------------
package priority_grant_pkg;

    // Widest request vector the onehot helper can decode.
    localparam int unsigned MAX_REQ = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot of id within an n-bit field; callers size-cast the result.
    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned id, input int unsigned n);
        logic [MAX_REQ-1:0] v;
        v = {MAX_REQ{1'b0}};
        for (int unsigned i = 32'd0; i < MAX_REQ; i++) begin
            v[i] = (i == id) && (i < n);
        end
        return v;
    endfunction

endpackage

// File: rtl/priority_encoder_param.sv
// -----------------------------------------------------------------------------
// priority_encoder_param
// Combinational highest-index-wins priority encoder.
//   vec   in  NUM_REQ   candidate vector
//   id    out ID_WIDTH  index of the highest set bit (0 when none set)
//   valid out 1         at least one bit of vec is set
// -----------------------------------------------------------------------------
module priority_encoder_param #(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  vec,
    output logic [ID_WIDTH-1:0] id,
    output logic                valid
);

    // Ascending scan: later (higher) set bits overwrite earlier ones.
    always_comb begin
        id    = {ID_WIDTH{1'b0}};
        valid = |vec;
        for (int i = 0; i < NUM_REQ; i++) begin
            id = vec[i] ? ID_WIDTH'(i) : id;
        end
    end

endmodule

// File: rtl/priority_grant_sequencer.sv
// -----------------------------------------------------------------------------
// priority_grant_sequencer
// Captures request pulses into sticky pending bits and grants them one at a
// time, highest index first, as an id on a valid/ready output.
//   clk       in   1         clock, rising edge
//   rst_n     in   1         synchronous active-low reset
//   req       in   NUM_REQ   request pulses/levels, sampled every cycle
//   out_id    out  ID_WIDTH  granted source index (holds last value)
//   out_valid out  1         out_id is valid
//   out_ready in   1         consumer accepts out_id
//   pending   out  NUM_REQ   current pending vector
//   merged    out  1         pulse: a request landed on an already-pending bit
//   mask      in   NUM_REQ   only when PRIORITY_GRANT_MASK_EN is defined;
//                            1 = source ineligible for selection
// Build option: PRIORITY_GRANT_MASK_EN adds the mask port.
// -----------------------------------------------------------------------------
module priority_grant_sequencer
    import priority_grant_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic [ID_WIDTH-1:0] out_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_REQ-1:0]  pending,
    output logic                merged
`ifdef PRIORITY_GRANT_MASK_EN
    ,
    input  logic [NUM_REQ-1:0]  mask
`endif
);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [NUM_REQ-1:0]    pending_r;
    logic [NUM_REQ-1:0]    pending_nxt_s;
    logic [ID_WIDTH-1:0]   out_id_r;
    logic                  out_valid_r;
    logic                  valid_nxt_s;
    logic                  merged_r;
    logic                  merged_nxt_s;
    logic                  hs_s;
    logic                  load_s;
    logic [NUM_REQ-1:0]    clr_vec_s;
    logic [NUM_REQ-1:0]    elig_s;
    logic [ID_WIDTH-1:0]   sel_id_s;
    logic                  sel_valid_s;

    assign hs_s = out_valid_r & out_ready;

    // Clear vector, pending/merged next values and eligibility.
    always_comb begin
        clr_vec_s     = {NUM_REQ{1'b0}};
        pending_nxt_s = pending_r;
        merged_nxt_s  = 1'b0;
        elig_s        = {NUM_REQ{1'b0}};
        if (hs_s) begin
            clr_vec_s = NUM_REQ'(onehot(32'(out_id_r), 32'(NUM_REQ)));
        end else begin
            clr_vec_s = {NUM_REQ{1'b0}};
        end
        // A new request wins over the clear of the bit just granted.
        pending_nxt_s = req | (pending_r & ~clr_vec_s);
        // Only a repeat that is absorbed into a still-pending bit is lost.
        merged_nxt_s  = |(req & pending_r & ~clr_vec_s);
        // Requests arriving this cycle are not yet eligible.
`ifdef PRIORITY_GRANT_MASK_EN
        elig_s        = pending_r & ~clr_vec_s & ~mask;
`else
        elig_s        = pending_r & ~clr_vec_s;
`endif
    end

    priority_encoder_param #(
        .NUM_REQ (NUM_REQ)
    ) u_enc (
        .vec   (elig_s),
        .id    (sel_id_s),
        .valid (sel_valid_s)
    );

    // Grant FSM next-state and output-load decisions.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = out_valid_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_valid_s) begin
                    load_s      = 1'b1;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = PRESENT;
                end else begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = IDLE;
                end
            end
            PRESENT: begin
                // Presented id is held until accepted; no preemption.
                if (hs_s) begin
                    if (sel_valid_s) begin
                        load_s      = 1'b1;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = PRESENT;
                    end else begin
                        valid_nxt_s = 1'b0;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    valid_nxt_s = 1'b1;
                    state_nxt_s = PRESENT;
                end
            end
            default: begin
                valid_nxt_s = 1'b0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pending and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pending_r   <= {NUM_REQ{1'b0}};
            out_id_r    <= {ID_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            merged_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            out_valid_r <= valid_nxt_s;
            merged_r    <= merged_nxt_s;
            if (load_s) begin
                out_id_r <= sel_id_s;
            end else begin
                out_id_r <= out_id_r;
            end
        end
    end

    assign out_id    = out_id_r;
    assign out_valid = out_valid_r;
    assign pending   = pending_r;
    assign merged    = merged_r;

endmodule
